// File: rtl/fifo_arb_ctrl_pkg.sv
// rtl/fifo_arb_ctrl_pkg.sv - shared state encodings and sizing for the FIFO arbiter controller
package fifo_arb_ctrl_pkg;

    localparam int STATE_BITS        = 3;
    localparam int DEFAULT_NUM_FIFOS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // Index width for a set of n FIFOs; never zero so a single FIFO still gets a legal vector.
    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_arb_ctrl_rr_arbiter.sv
// rtl/fifo_arb_ctrl_rr_arbiter.sv - combinational round-robin grant generator
//
// Ports:
//   req    - per-requester request bits
//   ptr    - index the search starts from (highest priority this cycle)
//   enable - when low no grant is issued
//   grant  - one-hot grant, all zero when disabled or nothing requests
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int PTR_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [PTR_BITS-1:0] ptr,
    input  logic                enable,
    output logic [NUM_REQ-1:0]  grant
);

    always_comb begin
        int                  idx;
        logic                found;
        logic [PTR_BITS-1:0] sel;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        // Walk ptr, ptr+1, ... wrapping at NUM_REQ; the first requester seen wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = PTR_BITS'(idx);
            if (enable && !found && req[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// rtl/fifo_arb_ctrl.sv - round-robin read controller for a bank of FIFOs feeding one downstream port
//
// Ports:
//   clk, reset                      - clock and synchronous active-low reset
//   init, high/low_limit_in         - threshold configuration request and values
//   fifo_empty, fifo_error          - per-FIFO status flags
//   fifo_data                       - FIFO outputs, FIFO i at [i*DATA_BITS +: DATA_BITS]
//   dest_full                       - downstream backpressure
//   fifo_read                       - one-hot combinational read strobes
//   high/low_limit_out              - configured thresholds broadcast to the FIFOs
//   data_out, valid_out             - forwarded word, one cycle after its read strobe
//   state_out, idle_out, error_out  - controller state indicators
module fifo_arb_ctrl
    import fifo_arb_ctrl_pkg::*;
#(
    parameter int DATA_BITS = 10,
    parameter int ADDR_BITS = 3,
    parameter int NUM_FIFOS = DEFAULT_NUM_FIFOS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           init,
    input  logic [ADDR_BITS-1:0]           high_limit_in,
    input  logic [ADDR_BITS-1:0]           low_limit_in,
    input  logic [NUM_FIFOS-1:0]           fifo_empty,
    input  logic [NUM_FIFOS-1:0]           fifo_error,
    input  logic [NUM_FIFOS*DATA_BITS-1:0] fifo_data,
    input  logic                           dest_full,
    output logic [NUM_FIFOS-1:0]           fifo_read,
    output logic [ADDR_BITS-1:0]           high_limit_out,
    output logic [ADDR_BITS-1:0]           low_limit_out,
    output logic [DATA_BITS-1:0]           data_out,
    output logic                           valid_out,
    output logic [2:0]                     state_out,
    output logic                           idle_out,
    output logic                           error_out
);

    localparam int PTR_BITS = ptr_bits(NUM_FIFOS);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] high_q, high_d;
    logic [ADDR_BITS-1:0] low_q, low_d;
    logic [PTR_BITS-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_BITS-1:0]  gnt_idx_q, gnt_idx_d;
    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_hold_q, data_hold_d;

    logic [NUM_FIFOS-1:0] req;
    logic [NUM_FIFOS-1:0] grant;
    logic [PTR_BITS-1:0]  gnt_idx;
    logic [DATA_BITS-1:0] sel_word;
    logic                 any_req;
    logic                 any_err;
    logic                 rd_en;
    logic                 granted;

    assign req     = ~fifo_empty;
    assign any_req = |req;
    assign any_err = |fifo_error;
    // An error flag kills the strobe in the same cycle it appears.
    assign rd_en   = (state_q == ST_ACTIVE) && !dest_full && !any_err && any_req;

    rr_arbiter #(
        .NUM_REQ  (NUM_FIFOS),
        .PTR_BITS (PTR_BITS)
    ) u_rr_arbiter (
        .req    (req),
        .ptr    (rr_ptr_q),
        .enable (rd_en),
        .grant  (grant)
    );

    assign fifo_read = grant;
    assign granted   = |grant;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (grant[i]) begin
                gnt_idx = PTR_BITS'(i);
            end
        end
    end

    // The FIFO presents its word one cycle after the strobe, so the mux follows the registered index.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (gnt_idx_q == PTR_BITS'(i)) begin
                sel_word = fifo_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        gnt_idx_d   = gnt_idx_q;
        valid_d     = granted;
        data_hold_d = valid_q ? sel_word : data_hold_q;
        if (granted) begin
            gnt_idx_d = gnt_idx;
            rr_ptr_d  = (gnt_idx == PTR_BITS'(NUM_FIFOS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        high_d  = high_q;
        low_d   = low_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (init) begin
                    high_d = high_limit_in;
                    low_d  = low_limit_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (any_err) begin
                    state_d = ST_ERROR;
                end else if (init) begin
                    state_d = ST_INIT;
                end else if (any_req) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (any_err) begin
                    state_d = ST_ERROR;
                end else if (!any_req && !granted) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_RESET;
            high_q      <= '0;
            low_q       <= '0;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            valid_q     <= 1'b0;
            data_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            high_q      <= high_d;
            low_q       <= low_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            valid_q     <= valid_d;
            data_hold_q <= data_hold_d;
        end
    end

    assign high_limit_out = high_q;
    assign low_limit_out  = low_q;
    assign valid_out      = valid_q;
    assign data_out       = valid_q ? sel_word : data_hold_q;
    assign state_out      = state_q;
    assign idle_out       = (state_q == ST_IDLE);
    assign error_out      = (state_q == ST_ERROR);

endmodule

// File: doc/fifo_arb_ctrl.md
FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 10, width of one FIFO word.
REQ-002 SHALL have parameter ADDR_BITS, default 3, width of the FIFO address and threshold fields.
REQ-003 SHALL have parameter NUM_FIFOS, default 4, number of arbitrated FIFOs.
REQ-004 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port init, input, 1, requests threshold configuration.
REQ-007 SHALL have ports high_limit_in and low_limit_in, input, ADDR_BITS each, threshold values to latch.
REQ-008 SHALL have port fifo_empty, input, NUM_FIFOS, per-FIFO empty flags.
REQ-009 SHALL have port fifo_error, input, NUM_FIFOS, per-FIFO error flags.
REQ-010 SHALL have port fifo_data, input, NUM_FIFOS*DATA_BITS, FIFO outputs; FIFO i occupies bits [i*DATA_BITS +: DATA_BITS].
REQ-011 SHALL have port dest_full, input, 1, downstream almost-full (backpressure).
REQ-012 SHALL have port fifo_read, output, NUM_FIFOS, one-hot read strobes.
REQ-013 SHALL have ports high_limit_out and low_limit_out, output, ADDR_BITS each, configured thresholds driven to every FIFO.
REQ-014 SHALL have port data_out, output, DATA_BITS, forwarded word.
REQ-015 SHALL have port valid_out, output, 1, data_out qualifier.
REQ-016 SHALL have port state_out, output, 3, current FSM state.
REQ-017 SHALL have ports idle_out and error_out, output, 1 each, state indicators.

Function
REQ-018 SHALL implement the states RESET=0, INIT=1, IDLE=2, ACTIVE=3 and ERROR=4.
REQ-019 SHALL move from RESET to INIT on the first clock with reset high.
REQ-020 SHALL, in INIT, load high_limit_in and low_limit_in into the limit registers every cycle while init=1.
REQ-021 SHALL move from INIT to IDLE on the first cycle with init=0; the limits hold their last loaded values.
REQ-022 SHALL, from IDLE, take the first matching transition in this priority order: any fifo_error bit set -> ERROR; init=1 -> INIT; any FIFO non-empty -> ACTIVE; otherwise stay in IDLE.
REQ-023 SHALL, from ACTIVE, go to ERROR if any fifo_error bit is set, go to IDLE if all FIFOs are empty and no read is issued that cycle, and otherwise stay in ACTIVE.
REQ-024 SHALL hold ERROR until reset; init is ignored there.
REQ-025 SHALL make fifo_read combinational: a one-hot grant only when state=ACTIVE, dest_full=0, fifo_error=0 and at least one FIFO is non-empty, otherwise all zero.
REQ-026 SHALL never assert a read for a FIFO whose fifo_empty bit is 1.
REQ-027 SHALL arbitrate round-robin: search from rr_ptr upward, modulo NUM_FIFOS, and grant the first non-empty FIFO.
REQ-028 SHALL, after a grant to FIFO g, set rr_ptr to (g+1) mod NUM_FIFOS; without a grant rr_ptr holds.
REQ-029 SHALL provide 1-cycle read latency: the cycle after fifo_read[g]=1, valid_out=1 and data_out equals FIFO g's data, selected by a registered grant index.
REQ-030 SHALL drive valid_out=0 in every cycle not preceded by a grant; data_out then holds its last value.
REQ-031 SHALL still deliver a word already in flight when dest_full rises, so the downstream needs one entry of slack.
REQ-032 SHALL, when fifo_error rises during ACTIVE, deassert fifo_read in that same cycle and still deliver any word in flight.
REQ-033 SHALL drive idle_out=1 only in IDLE and error_out=1 only in ERROR.

Reset
REQ-034 SHALL, with reset=0 at a clock edge, set state=RESET, both limit registers=0 (0 means full-only), rr_ptr=0, valid_out=0, data_out=0 and registered grant=0.
REQ-035 SHALL drive fifo_read=0 while in RESET.
REQ-036 SHALL, on reset asserted mid-transfer, drop any in-flight word, so valid_out=0 on the next cycle.

Structure
REQ-037 SHALL place state encodings, the default NUM_FIFOS and the state width in a shared package.
REQ-038 SHALL implement grant generation in one sub-module, rr_arbiter, which takes request, pointer and enable and returns a one-hot grant.

Verification
REQ-039 SHALL cover: reset, then init=1 with high=6, low=2 for 2 cycles, then init=0 -> high_limit_out=6 and low_limit_out=2, state sequence 0->1->2.
REQ-040 SHALL cover: all four FIFOs non-empty with dest_full=0 -> fifo_read sequence 0001, 0010, 0100, 1000, 0001; each valid_out 1 cycle later with the matching word.
REQ-041 SHALL cover: only FIFO 2 non-empty with rr_ptr=3 -> grant 0100 and rr_ptr becomes 3.
REQ-042 SHALL cover: dest_full raised for 3 cycles mid-stream -> fifo_read=0 for those cycles, exactly one in-flight valid_out, then resume at the next round-robin FIFO.
REQ-043 SHALL cover: fifo_error[1] set in ACTIVE -> fifo_read=0 in the same cycle, state=4 next cycle, error_out stays 1 until reset.
REQ-044 SHALL cover: reset=0 asserted in the cycle after a grant -> valid_out=0, state=0 and limits=0 on the following cycle.
